// File: rtl/lcd_hd44780_bus_ctrl.sv
// lcd_hd44780_bus_ctrl
// Avalon-MM slave that turns each read or write into one timed HD44780 bus cycle
// (setup, E pulse, hold), stalling the master with waitrequest until the cycle is
// complete. With DATA_BUS_WIDTH = 4 each byte is moved as two nibbles, high first.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address[1:0]            bit0 = LCD RW (1 = read), bit1 = LCD RS
//   read, write             Avalon strobes; either one starts a cycle
//   writedata[7:0]          byte to send
//   readdata[7:0]           last byte captured from the LCD (registered)
//   waitrequest             Avalon stall
//   LCD_E, LCD_RS, LCD_RW   registered LCD control outputs
//   LCD_data                tristate LCD data bus
module lcd_hd44780_bus_ctrl #(
  parameter int unsigned DATA_BUS_WIDTH = 8,
  parameter int unsigned T_SETUP        = 2,
  parameter int unsigned T_PULSE        = 12,
  parameter int unsigned T_HOLD         = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [1:0]                address,
  input  logic                      read,
  input  logic                      write,
  input  logic [7:0]                writedata,
  output logic [7:0]                readdata,
  output logic                      waitrequest,
  output logic                      LCD_E,
  output logic                      LCD_RS,
  output logic                      LCD_RW,
  inout  wire  [DATA_BUS_WIDTH-1:0] LCD_data
);

  localparam int unsigned MaxSP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned MaxT  = (MaxSP > T_HOLD) ? MaxSP : T_HOLD;
  localparam int unsigned CntW  = $clog2(MaxT + 1);
  localparam bit          NibbleMode = (DATA_BUS_WIDTH == 4);

  if (!((DATA_BUS_WIDTH == 8) || (DATA_BUS_WIDTH == 4))) begin : g_err_width
    $error("lcd_hd44780_bus_ctrl: DATA_BUS_WIDTH must be 8 or 4");
  end
  if ((T_SETUP < 1) || (T_PULSE < 1) || (T_HOLD < 1)) begin : g_err_timing
    $error("lcd_hd44780_bus_ctrl: T_SETUP, T_PULSE and T_HOLD must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              nibble_q, nibble_d;
  logic              rw_q, rw_d;
  logic              rs_q, rs_d;
  logic [7:0]        wd_q, wd_d;
  logic              done_q, done_d;
  logic              e_q, e_d;
  logic [7:0]        readdata_q, readdata_d;
  logic              capture;
  logic              last_nibble;
  logic              drive;
  logic [DATA_BUS_WIDTH-1:0] bus_out;

  // In 8-bit mode every HOLD is the last one.
  assign last_nibble = !NibbleMode || nibble_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nibble_d = nibble_q;
    rw_d     = rw_q;
    rs_d     = rs_q;
    wd_d     = wd_q;
    unique case (state_q)
      StIdle: begin
        if (read || write) begin
          rw_d     = address[0];
          rs_d     = address[1];
          wd_d     = writedata;
          nibble_d = 1'b0;
          state_d  = StSetup;
          cnt_d    = CntW'(T_SETUP);
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StPulse;
          cnt_d   = CntW'(T_PULSE);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPulse: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StHold;
          cnt_d   = CntW'(T_HOLD);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == CntW'(1)) begin
          if (!last_nibble) begin
            state_d  = StSetup;
            cnt_d    = CntW'(T_SETUP);
            nibble_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // done is high exactly on the final HOLD cycle of the last nibble.
  assign done_d  = (state_d == StHold) && (cnt_d == CntW'(1)) && last_nibble;
  assign e_d     = (state_d == StPulse);
  // Sample on the last E-high cycle, while the LCD is still driving.
  assign capture = (state_q == StPulse) && (cnt_q == CntW'(1)) && rw_q;
  assign drive   = !rw_q && (state_q != StIdle);

  if (NibbleMode) begin : g_nibble
    always_comb begin
      readdata_d = readdata_q;
      if (capture) begin
        if (nibble_q) readdata_d[3:0] = LCD_data;
        else          readdata_d[7:4] = LCD_data;
      end
    end
    assign bus_out = nibble_q ? wd_q[3:0] : wd_q[7:4];
  end else begin : g_byte
    always_comb begin
      readdata_d = readdata_q;
      if (capture) readdata_d = LCD_data;
    end
    assign bus_out = wd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      nibble_q   <= 1'b0;
      rw_q       <= 1'b0;
      rs_q       <= 1'b0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      e_q        <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nibble_q   <= nibble_d;
      rw_q       <= rw_d;
      rs_q       <= rs_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      e_q        <= e_d;
      readdata_q <= readdata_d;
    end
  end

  assign LCD_data    = drive ? bus_out : {DATA_BUS_WIDTH{1'bz}};
  assign LCD_E       = e_q;
  assign LCD_RS      = rs_q;
  assign LCD_RW      = rw_q;
  assign readdata    = readdata_q;
  assign waitrequest = (read | write) & ~done_q;

endmodule

// File: tb/tb_lcd_hd44780_bus_ctrl.sv
// Testbench for lcd_hd44780_bus_ctrl. Three instances: A (8-bit, default timing),
// B (4-bit, default timing), C (8-bit, 1/1/1 timing). Expected waveforms are derived
// cycle by cycle from the timing rules; a small LCD model drives the bus on reads.
module tb_lcd_hd44780_bus_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rd_a, wr_a, wait_a, e_a, rs_a, rw_a;
  logic [1:0] addr_a;
  logic [7:0] wd_a, rdd_a, drv_a;
  wire  [7:0] bus_a;

  logic       rd_b, wr_b, wait_b, e_b, rs_b, rw_b;
  logic [1:0] addr_b;
  logic [7:0] wd_b, rdd_b;
  logic [3:0] drv_b;
  wire  [3:0] bus_b;

  logic       rd_c, wr_c, wait_c, e_c, rs_c, rw_c;
  logic [1:0] addr_c;
  logic [7:0] wd_c, rdd_c, drv_c;
  wire  [7:0] bus_c;

  // LCD model: drives the bus only while E is high on a read; pull-ups show release.
  assign bus_a = (e_a && rw_a) ? drv_a : 8'bz;
  assign bus_b = (e_b && rw_b) ? drv_b : 4'bz;
  assign bus_c = (e_c && rw_c) ? drv_c : 8'bz;
  for (genvar i = 0; i < 8; i++) begin : g_pu_a
    pullup (bus_a[i]);
    pullup (bus_c[i]);
  end
  for (genvar i = 0; i < 4; i++) begin : g_pu_b
    pullup (bus_b[i]);
  end

  lcd_hd44780_bus_ctrl u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(addr_a), .read(rd_a), .write(wr_a),
    .writedata(wd_a), .readdata(rdd_a), .waitrequest(wait_a), .LCD_E(e_a),
    .LCD_RS(rs_a), .LCD_RW(rw_a), .LCD_data(bus_a)
  );

  lcd_hd44780_bus_ctrl #(.DATA_BUS_WIDTH(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(addr_b), .read(rd_b), .write(wr_b),
    .writedata(wd_b), .readdata(rdd_b), .waitrequest(wait_b), .LCD_E(e_b),
    .LCD_RS(rs_b), .LCD_RW(rw_b), .LCD_data(bus_b)
  );

  lcd_hd44780_bus_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .address(addr_c), .read(rd_c), .write(wr_c),
    .writedata(wd_c), .readdata(rdd_c), .waitrequest(wait_c), .LCD_E(e_c),
    .LCD_RS(rs_c), .LCD_RW(rw_c), .LCD_data(bus_c)
  );

  // Counts rising edges of E on instance C.
  logic e_c_prev = 1'b0;
  int   pulses_c = 0;
  always @(negedge clk) begin
    if (e_c && !e_c_prev) pulses_c <= pulses_c + 1;
    e_c_prev <= e_c;
  end

  // Reference state per instance (0 = A, 1 = B, 2 = C).
  logic       last_rs [3];
  logic       last_rw [3];
  logic [7:0] exp_rd  [3];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req8(input int w, input logic rd, input logic wr,
                          input logic [1:0] a, input logic [7:0] d);
    if (w == 0) begin
      rd_a = rd; wr_a = wr; addr_a = a; wd_a = d;
    end else begin
      rd_c = rd; wr_c = wr; addr_c = a; wd_c = d;
    end
  endtask

  task automatic sample8(input int w, output logic e, output logic rs, output logic rw,
                         output logic wt, output logic [7:0] bus, output logic [7:0] rdd);
    if (w == 0) begin
      e = e_a; rs = rs_a; rw = rw_a; wt = wait_a; bus = bus_a; rdd = rdd_a;
    end else begin
      e = e_c; rs = rs_c; rw = rw_c; wt = wait_c; bus = bus_c; rdd = rdd_c;
    end
  endtask

  // One 8-bit transaction starting at the current cycle (cycle 0). With chain set the
  // request is left for the caller to replace on the very next cycle.
  task automatic run8(input int w, input logic rd, input logic wr, input logic [1:0] a,
                      input logic [7:0] d, input logic [7:0] rv, input bit chain);
    int ts, tp, th, tot, k;
    logic e, rs, rw, wt, ee;
    logic [7:0] bus, rdd, ebus;
    k  = (w == 0) ? 0 : 2;
    ts = (w == 0) ? 2 : 1;
    tp = (w == 0) ? 12 : 1;
    th = (w == 0) ? 2 : 1;
    tot = ts + tp + th;
    if (w == 0) drv_a = rv; else drv_c = rv;
    set_req8(w, rd, wr, a, d);
    for (int c = 0; c <= tot; c++) begin
      @(negedge clk);
      sample8(w, e, rs, rw, wt, bus, rdd);
      ee = (c >= ts + 1) && (c <= ts + tp);
      if (c == 0)     ebus = 8'hFF;
      else if (!a[0]) ebus = d;
      else            ebus = ee ? rv : 8'hFF;
      chk($sformatf("i%0d c%0d E", k, c), {7'd0, e}, {7'd0, ee});
      chk($sformatf("i%0d c%0d RS", k, c), {7'd0, rs}, {7'd0, (c == 0) ? last_rs[k] : a[1]});
      chk($sformatf("i%0d c%0d RW", k, c), {7'd0, rw}, {7'd0, (c == 0) ? last_rw[k] : a[0]});
      chk($sformatf("i%0d c%0d waitreq", k, c), {7'd0, wt}, {7'd0, c != tot});
      chk($sformatf("i%0d c%0d bus", k, c), bus, ebus);
      if (c == 0) chk($sformatf("i%0d c0 readdata", k), rdd, exp_rd[k]);
      if (c == tot) chk($sformatf("i%0d done readdata", k), rdd, a[0] ? rv : exp_rd[k]);
      @(posedge clk);
      #1;
    end
    last_rs[k] = a[1];
    last_rw[k] = a[0];
    if (a[0]) exp_rd[k] = rv;
    if (!chain) begin
      set_req8(w, 1'b0, 1'b0, a, d);
      @(negedge clk);
      sample8(w, e, rs, rw, wt, bus, rdd);
      chk($sformatf("i%0d idle E", k), {7'd0, e}, 8'd0);
      chk($sformatf("i%0d idle waitreq", k), {7'd0, wt}, 8'd0);
      chk($sformatf("i%0d idle bus", k), bus, 8'hFF);
      chk($sformatf("i%0d idle RS", k), {7'd0, rs}, {7'd0, last_rs[k]});
      chk($sformatf("i%0d idle readdata", k), rdd, exp_rd[k]);
      @(posedge clk);
      #1;
    end
  endtask

  // One 4-bit transaction on instance B: two 16-cycle nibble cycles back to back.
  task automatic run4(input logic rd, input logic wr, input logic [1:0] a,
                      input logic [7:0] d, input logic [3:0] hi, input logic [3:0] lo);
    int p;
    logic ee, first;
    logic [3:0] ebus;
    rd_b = rd; wr_b = wr; addr_b = a; wd_b = d;
    for (int c = 0; c <= 32; c++) begin
      first = (c <= 16);
      drv_b = first ? hi : lo;
      p = (c >= 1) ? ((c - 1) % 16) + 1 : 0;
      ee = (c >= 1) && (p >= 3) && (p <= 14);
      if (c == 0)     ebus = 4'hF;
      else if (!a[0]) ebus = first ? d[7:4] : d[3:0];
      else            ebus = ee ? (first ? hi : lo) : 4'hF;
      @(negedge clk);
      chk($sformatf("i1 c%0d E", c), {7'd0, e_b}, {7'd0, ee});
      chk($sformatf("i1 c%0d RS", c), {7'd0, rs_b}, {7'd0, (c == 0) ? last_rs[1] : a[1]});
      chk($sformatf("i1 c%0d RW", c), {7'd0, rw_b}, {7'd0, (c == 0) ? last_rw[1] : a[0]});
      chk($sformatf("i1 c%0d waitreq", c), {7'd0, wait_b}, {7'd0, c != 32});
      chk($sformatf("i1 c%0d bus", c), {4'd0, bus_b}, {4'd0, ebus});
      if (c == 32) chk("i1 done readdata", rdd_b, a[0] ? {hi, lo} : exp_rd[1]);
      @(posedge clk);
      #1;
    end
    last_rs[1] = a[1];
    last_rw[1] = a[0];
    if (a[0]) exp_rd[1] = {hi, lo};
    rd_b = 1'b0; wr_b = 1'b0;
    @(negedge clk);
    chk("i1 idle E", {7'd0, e_b}, 8'd0);
    chk("i1 idle waitreq", {7'd0, wait_b}, 8'd0);
    chk("i1 idle bus", {4'd0, bus_b}, 8'h0F);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0, sel;
    logic [1:0] a;
    logic [7:0] d, rv;
    reset_n = 1'b0;
    rd_a = 0; wr_a = 1; addr_a = 2'b00; wd_a = 8'h00; drv_a = 8'h00;
    rd_b = 0; wr_b = 0; addr_b = 2'b00; wd_b = 8'h00; drv_b = 4'h0;
    rd_c = 0; wr_c = 0; addr_c = 2'b00; wd_c = 8'h00; drv_c = 8'h00;
    for (int i = 0; i < 3; i++) begin
      last_rs[i] = 1'b0; last_rw[i] = 1'b0; exp_rd[i] = 8'h00;
    end

    // Reset with a write pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst E", {7'd0, e_a}, 8'd0);
    chk("rst RS", {7'd0, rs_a}, 8'd0);
    chk("rst RW", {7'd0, rw_a}, 8'd0);
    chk("rst readdata", rdd_a, 8'h00);
    chk("rst bus", bus_a, 8'hFF);
    chk("rst waitreq", {7'd0, wait_a}, 8'd1);
    chk("rst bus4", {4'd0, bus_b}, 8'h0F);
    wr_a = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed 8-bit write and read on A.
    run8(0, 1'b0, 1'b1, 2'b00, 8'h38, 8'h00, 1'b0);
    run8(0, 1'b1, 1'b0, 2'b11, 8'h00, 8'hA5, 1'b0);

    // Random transactions on A, including simultaneous read and write.
    for (int i = 0; i < 8; i++) begin
      a   = 2'($urandom_range(0, 3));
      d   = 8'($urandom);
      rv  = 8'($urandom);
      sel = $urandom_range(0, 2);
      run8(0, sel != 1, sel != 0, a, d, rv, 1'b0);
    end

    // Reset during cycle 8 of a write.
    set_req8(0, 1'b0, 1'b1, 2'b10, 8'h3C);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("pre-rst E", {7'd0, e_a}, 8'd1);
    reset_n = 1'b0;
    #1;
    chk("mid-rst E", {7'd0, e_a}, 8'd0);
    chk("mid-rst bus", bus_a, 8'hFF);
    chk("mid-rst RS", {7'd0, rs_a}, 8'd0);
    chk("mid-rst waitreq", {7'd0, wait_a}, 8'd1);
    wr_a = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      last_rs[i] = 1'b0; last_rw[i] = 1'b0; exp_rd[i] = 8'h00;
    end
    @(posedge clk); #1;
    run8(0, 1'b0, 1'b1, 2'b10, 8'h38, 8'h00, 1'b0);

    // 4-bit mode on B.
    run4(1'b0, 1'b1, 2'b10, 8'h5C, 4'h0, 4'h0);
    run4(1'b1, 1'b0, 2'b01, 8'h00, 4'h9, 4'h3);
    run4(1'b1, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom), 4'($urandom));

    // Back-to-back writes on C with 1/1/1 timing.
    p0 = pulses_c;
    run8(1, 1'b0, 1'b1, 2'b00, 8'h01, 8'h00, 1'b1);
    run8(1, 1'b0, 1'b1, 2'b00, 8'h02, 8'h00, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("b2b pulse count", 8'(pulses_c - p0), 8'd2);

    for (int i = 0; i < 6; i++) begin
      sel = $urandom_range(0, 2);
      run8(1, sel != 1, sel != 0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           i < 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_bus_ctrl.md
# lcd_hd44780_bus_ctrl

Parametrised Avalon-MM slave for HD44780-compatible character LCDs, replacing the zero-wait-state LCD port in the SoC system. Each Avalon read or write becomes one properly timed LCD bus cycle with programmable setup, E-pulse and hold times. Avalon `waitrequest` stalls the master until the cycle completes. An optional 4-bit mode transfers each byte as two nibbles.

## Interface
Parameters:
- `DATA_BUS_WIDTH`, default 8: LCD data pins; must be 8 or 4. 4 selects nibble mode, high nibble first.
- `T_SETUP`, default 2: clk cycles RS/RW/data are stable before E rises; ≥1.
- `T_PULSE`, default 12: clk cycles E is high; ≥1.
- `T_HOLD`, default 2: clk cycles after E falls before the bus is released or the next nibble starts; ≥1.
- Any illegal value raises an elaboration error.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: bit0 is LCD RW (1 = LCD read); bit1 is LCD RS.
- `read` in 1: Avalon read strobe.
- `write` in 1: Avalon write strobe.
- `writedata` in 8: byte to send.
- `readdata` out 8: registered byte captured from the LCD.
- `waitrequest` out 1: Avalon stall.
- `LCD_E` out 1: enable strobe, registered.
- `LCD_RS` out 1: register select, registered.
- `LCD_RW` out 1: read/write, registered.
- `LCD_data` inout `DATA_BUS_WIDTH`: tristate data bus.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD. One down-counter is sized for max(T_*). A nibble flag is used only when `DATA_BUS_WIDTH`=4.
- Starting a transaction:
  - In IDLE with `read|write`=1, latch `address`, `writedata` and direction `rw_q=address[0]`.
  - Go to SETUP with the counter loaded to T_SETUP.
  - Direction comes only from `address[0]`; the `read`/`write` strobes only start the cycle.
- State transitions:
  - SETUP: after T_SETUP cycles, go to PULSE.
  - PULSE: `LCD_E`=1 for T_PULSE cycles, then go to HOLD.
  - HOLD: after T_HOLD cycles, either go to SETUP for the second nibble (4-bit, first nibble) or raise `done` for one cycle and return to IDLE.
- Output driving:
  - `LCD_RS`/`LCD_RW` follow the latched address from SETUP through HOLD, and keep their last value in IDLE.
  - `LCD_data` is driven only when `rw_q`=0 and state≠IDLE. 8-bit mode drives the latched byte. 4-bit mode drives `wd_q[7:4]` on the first nibble and `wd_q[3:0]` on the second.
  - `LCD_data` is high-Z otherwise.
- Read capture:
  - On the last PULSE cycle with `rw_q`=1, sample `LCD_data` while E is still high.
  - 8-bit mode writes the sample to `readdata[7:0]`.
  - 4-bit mode writes the first nibble to `readdata[7:4]` and the second to `readdata[3:0]`.
  - `readdata` holds between captures and is not updated on LCD writes.
- `waitrequest = (read|write) & ~done`, combinational. `done` is registered and high only on the final HOLD cycle.
- Simultaneous `read` and `write` is treated as one transaction, with direction taken from `address[0]`.
- A request arriving in the same cycle as `done` is the current request completing. The FSM is IDLE on the next cycle, so a new request then starts a new transaction.
- Reset mid-transaction: the transaction is abandoned immediately with no further E strobe, and the master must reissue.

## Timing
- Reset values:
  - `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=0.
  - `LCD_data` high-Z, `readdata`=0x00, state IDLE, `done`=0.
  - `waitrequest` follows `read|write` while in reset.
- Per-byte timing, with cycle 0 = request first seen in IDLE:
  - SETUP spans cycles 1..T_SETUP.
  - E is high on cycles T_SETUP+1..T_SETUP+T_PULSE.
  - `done`/`waitrequest`=0 on cycle T_SETUP+T_PULSE+T_HOLD; with defaults this is cycle 16.
- 4-bit mode: the second nibble's SETUP follows the first HOLD immediately, so `done` falls on cycle 2·(T_SETUP+T_PULSE+T_HOLD); with defaults this is cycle 32.
- Back-to-back throughput: one byte per (T_S+T_P+T_H)+1 cycles in 8-bit mode.
- `LCD_RS`, `LCD_RW` and `LCD_data` never change while `LCD_E`=1.

## Test plan
- Reset and idle:
  - Stimulus: assert `reset_n`=0 with `write`=1, then release.
  - Required: E/RS/RW=0, `readdata`=0x00, bus high-Z, `waitrequest`=1.
- 8-bit write:
  - Stimulus: defaults; write 0x38 to address 0.
  - Required: RS=0, RW=0, bus=0x38 from cycle 1.
  - Required: E high on cycles 3–14 only, `waitrequest` low on cycle 16, bus high-Z on cycle 17.
- 8-bit read:
  - Stimulus: model drives 0xA5 while E is high; read address 3.
  - Required: RS=1, RW=1, the controller never drives the bus, `readdata`=0xA5 when `waitrequest` drops.
- 4-bit mode:
  - Stimulus: `DATA_BUS_WIDTH`=4; write 0x5C to address 2.
  - Required: two E pulses carrying 0x5 then 0xC, with RS=1.
  - Required: a read that returns 0x9 then 0x3 gives `readdata`=0x93, with `done` on cycle 32.
- Reset mid-pulse:
  - Stimulus: drop `reset_n` during cycle 8 of a write.
  - Required: E=0 immediately, bus high-Z, FSM IDLE.
  - Required: a subsequent write completes with normal timing.
- Back-to-back writes with non-default parameters:
  - Stimulus: `T_SETUP`=1, `T_PULSE`=1, `T_HOLD`=1; write 0x01 then immediately 0x02.
  - Required: each `waitrequest` drops on cycle 3 of its own transaction.
  - Required: exactly two E pulses, no request is restarted after `done`, RS/RW/data are stable during each E.
